// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
// State encoding and default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder built from two half adders.
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (i_cin),
    .o_s (o_s),
    .o_c (w_c1)
  );

  assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// Combinational 1-bit half adder.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell stepped LSB-first
// over WIDTH cycles, with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cf;
  logic             r_carry;
  logic             w_s;
  logic             w_cout;
  logic             w_last;

  fa_bit u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_cf),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cf    <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_a_sh <= in1;
        r_b_sh <= sub ? ~in2 : in2;
        r_cf   <= sub;
        r_cnt  <= '0;
        r_res  <= '0;
      end else if (r_state == ST_RUN) begin
        r_res  <= {w_s, r_res[WIDTH-1:1]};
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_cf   <= w_cout;
        // Park the counter at zero instead of letting it wrap
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_sum   <= {w_s, r_res[WIDTH-1:1]};
          r_carry <= w_cout;
        end
      end
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_DONE);
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Vector table plus hand-written multi-cycle sequences.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int n_tests;
  int n_fail;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One start pulse; returns edges-to-done and busy cycle count.
  task automatic do_op(input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat,
                       output int nb);
    lat = -1;
    nb  = 0;
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (done && lat < 0) lat = i;
    end
  endtask

  initial begin
    int lat;
    int nb;
    int ndone;
    int t1;
    int t2;
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{1'b0, 8'h3C, 8'h0A, 8'h46, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0};
    vecs[3] = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    in1   = '0;
    in2   = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      do_op(vecs[k].sub, vecs[k].a, vecs[k].b, lat, nb);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'd8);
      chk($sformatf("v%0d_busy_cycles", k), 32'(nb), 32'd9);
      chk($sformatf("v%0d_sum", k), 32'(sum), 32'(vecs[k].exp_sum));
      chk($sformatf("v%0d_carry", k), 32'(carry), 32'(vecs[k].exp_carry));
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_sum_hold", k), 32'(sum), 32'(vecs[k].exp_sum));
      chk($sformatf("v%0d_carry_hold", k), 32'(carry),
          32'(vecs[k].exp_carry));
    end

    // start during RUN is ignored
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    in1   = 8'h10;
    in2   = 8'h20;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    s1    = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1;
        in1   = 8'hAA;
        in2   = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        s1 = sum;
      end
    end
    chk("busy_ignore_done_count", 32'(ndone), 32'd1);
    chk("busy_ignore_sum", 32'(s1), 32'h30);
    chk("busy_ignore_idle", 32'(busy), 32'd0);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1;
    in1   = 8'h81;
    in2   = 8'h81;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort_no_activity", 32'(ndone), 32'd0);
    do_op(1'b0, 8'h01, 8'h01, lat, nb);
    chk("post_abort_sum", 32'(sum), 32'h02);
    chk("post_abort_latency", 32'(lat), 32'd8);

    // start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    in1   = 8'h01;
    in2   = 8'h02;
    t1    = -1;
    t2    = -1;
    s1    = '0;
    s2    = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in1 = 8'h10;
        in2 = 8'h20;
      end
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          s1 = sum;
        end else begin
          t2 = i;
          s2 = sum;
          start = 1'b0;
          break;
        end
      end
    end
    chk("b2b_first_sum", 32'(s1), 32'h03);
    chk("b2b_second_sum", 32'(s2), 32'h30);
    chk("b2b_spacing", 32'(t2 - t1), 32'd10);
    repeat (3) @(negedge clk);
    chk("b2b_stop_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
